// File: rtl/bus_dev_fifo.sv
// -----------------------------------------------------------------------------
// bus_dev_fifo
//
// Per-terminal source FIFO feeding the parallel bus. The driver side enqueues
// packages with wr/wr_data; the bus side sees the head package on D_pop
// (show-ahead) whenever pndng is high and consumes it with pop.
//
// Ports
//   clock     : single clock, all state changes on the rising edge
//   reset     : asynchronous active-low reset
//   wr        : write strobe, enqueues wr_data this cycle
//   wr_data   : package to enqueue
//   pop       : bus consumes the head package this cycle
//   D_pop     : head package, 0 when empty
//   pndng     : FIFO non-empty
//   full      : occupancy equals depth
//   count     : current occupancy
//   overflow  : sticky, a write was dropped because the FIFO was full
//   underflow : sticky, a pop arrived while the FIFO was empty
//   drop_cnt  : number of dropped writes, saturating at 255
// -----------------------------------------------------------------------------
module bus_dev_fifo #(
  parameter int pckg_sz = 16,
  parameter int depth   = 8,
  parameter int id      = 0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       wr,
  input  logic [pckg_sz-1:0]         wr_data,
  input  logic                       pop,
  output logic [pckg_sz-1:0]         D_pop,
  output logic                       pndng,
  output logic                       full,
  output logic [$clog2(depth+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow,
  output logic [7:0]                 drop_cnt
);

  localparam int aw = $clog2(depth);
  localparam int cw = $clog2(depth + 1);

  logic [pckg_sz-1:0] mem [depth];
  logic [aw-1:0]      wr_ptr;
  logic [aw-1:0]      rd_ptr;
  logic               do_wr;
  logic               do_pop;

  // Status comes only from the registered count, so there is no
  // combinational path from wr/pop to pndng, full or D_pop.
  assign pndng = (count != '0);
  assign full  = (count == cw'(depth));
  assign D_pop = pndng ? mem[rd_ptr] : '0;

  // A pop on an empty FIFO is ignored. A pop at full frees a slot in the same
  // edge, so a simultaneous write is still accepted.
  assign do_pop = pop && pndng;
  assign do_wr  = wr && (!full || do_pop);

  // NOTE: the storage array has no reset; the occupancy count gates D_pop, so
  // stale contents after a reset are never visible and the array can map to RAM.
  always_ff @(posedge clock) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + aw'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + aw'(1);
      end

      case ({do_wr, do_pop})
        2'b10:   count <= count + cw'(1);
        2'b01:   count <= count - cw'(1);
        default: count <= count;
      endcase

      if (wr && !do_wr) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hFF) begin
          drop_cnt <= drop_cnt + 8'd1;
        end
      end

      if (pop && !pndng) begin
        underflow <= 1'b1;
      end
    end
  end

  // Simulation diagnostic for a bus popping an empty terminal; no effect on
  // the datapath.
  always_ff @(posedge clock) begin
    if (reset && pop && !pndng) begin
      $warning("bus_dev_fifo[%0d]: pop while empty", id);
    end
  end

endmodule
